// File: rtl/mem_req_scheduler_pkg.sv
// Shared types for mem_req_scheduler: FSM state encoding and an index-width helper.
package mem_req_scheduler_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ENC_IDLE      = 2'd0;
    localparam logic [STATE_W-1:0] ENC_ISSUE     = 2'd1;
    localparam logic [STATE_W-1:0] ENC_WAIT_RESP = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = ENC_IDLE,
        ST_ISSUE     = ENC_ISSUE,
        ST_WAIT_RESP = ENC_WAIT_RESP
    } state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/mem_req_scheduler_rr_select.sv
// Combinational round-robin pick: searches from last_grant+1 upward, wrapping, lowest index first.
module rr_select
    import mem_req_scheduler_pkg::*;
#(
    parameter int PORTS = 4,
    parameter int IDW   = idx_width(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [IDW-1:0]   last_grant,
    output logic [IDW-1:0]   winner,
    output logic             valid
);

    localparam int EXT_W = IDW + 1;

    logic [EXT_W-1:0] cand_s;
    logic             found_s;

    // Scan every offset once; the first hit after last_grant wins
    always_comb begin
        winner  = {IDW{1'b0}};
        found_s = 1'b0;
        cand_s  = {EXT_W{1'b0}};
        for (int i = 1; i <= PORTS; i++) begin
            cand_s = {1'b0, last_grant} + EXT_W'(i);
            if (cand_s >= EXT_W'(PORTS)) begin
                cand_s = cand_s - EXT_W'(PORTS);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && req[cand_s[IDW-1:0]]) begin
                found_s = 1'b1;
                winner  = cand_s[IDW-1:0];
            end else begin
                found_s = found_s;
            end
        end
        valid = found_s;
    end

endmodule

// File: rtl/mem_req_scheduler.sv
// Single-outstanding memory request scheduler with round-robin arbitration.
// Optional response watchdog enabled by defining MEM_REQ_SCHEDULER_TIMEOUT_EN.
module mem_req_scheduler
    import mem_req_scheduler_pkg::*;
#(
    parameter int PORTS          = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS-1:0]            req_valid,
    output logic [PORTS-1:0]            req_ready,
    input  logic [PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [PORTS*DATA_WIDTH-1:0] req_wdata,
    input  logic [PORTS-1:0]            req_we,
    output logic [PORTS-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_rdata,
    output logic                        rsp_err,
    output logic                        m_valid,
    output logic [ADDR_WIDTH-1:0]       m_addr,
    output logic [DATA_WIDTH-1:0]       m_wdata,
    output logic                        m_we,
    input  logic                        m_ready,
    input  logic                        m_rsp_valid,
    input  logic [DATA_WIDTH-1:0]       m_rsp_rdata,
    input  logic                        m_rsp_err,
    output logic                        busy,
    output logic [$clog2(PORTS)-1:0]    grant_id
);

    localparam int IDW = $clog2(PORTS);

    state_e                state_q, state_d;
    logic [IDW-1:0]        grant_id_q, grant_id_d;
    logic [IDW-1:0]        last_grant_q, last_grant_d;
    logic                  m_valid_q, m_valid_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
    logic                  m_we_q, m_we_d;
    logic                  busy_q, busy_d;
    logic [PORTS-1:0]      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [PORTS-1:0]      req_ready_s;

    logic [IDW-1:0]        winner_s;
    logic                  sel_valid_s;
    logic [ADDR_WIDTH-1:0] addr_arr_s  [PORTS];
    logic [DATA_WIDTH-1:0] wdata_arr_s [PORTS];

`ifdef MEM_REQ_SCHEDULER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    rr_select #(
        .PORTS (PORTS),
        .IDW   (IDW)
    ) u_rr_select (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .winner     (winner_s),
        .valid      (sel_valid_s)
    );

    // Unpack the flat per-port address and write-data buses
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            addr_arr_s[p]  = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_arr_s[p] = req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Next-state and next-output logic for the transaction FSM
    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        m_valid_d    = m_valid_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        m_we_d       = m_we_q;
        busy_d       = busy_q;
        rsp_valid_d  = {PORTS{1'b0}};
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        req_ready_s  = {PORTS{1'b0}};
`ifdef MEM_REQ_SCHEDULER_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (sel_valid_s) begin
                    req_ready_s[winner_s] = 1'b1;
                    m_addr_d   = addr_arr_s[winner_s];
                    m_wdata_d  = wdata_arr_s[winner_s];
                    m_we_d     = req_we[winner_s];
                    grant_id_d = winner_s;
                    m_valid_d  = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = ST_WAIT_RESP;
`ifdef MEM_REQ_SCHEDULER_TIMEOUT_EN
                    cnt_d     = {CNT_W{1'b0}};
`endif
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT_RESP: begin
                if (m_rsp_valid) begin
                    rsp_valid_d[grant_id_q] = 1'b1;
                    rsp_rdata_d  = m_rsp_rdata;
                    rsp_err_d    = m_rsp_err;
                    last_grant_d = grant_id_q;
                    busy_d       = 1'b0;
                    state_d      = ST_IDLE;
                end
`ifdef MEM_REQ_SCHEDULER_TIMEOUT_EN
                // A real response in the same cycle as expiry takes precedence
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_valid_d[grant_id_q] = 1'b1;
                    rsp_rdata_d  = {DATA_WIDTH{1'b0}};
                    rsp_err_d    = 1'b1;
                    last_grant_d = grant_id_q;
                    busy_d       = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                else begin
                    state_d = ST_WAIT_RESP;
                end
`endif
            end
            default: begin
                state_d   = ST_IDLE;
                m_valid_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_id_q   <= {IDW{1'b0}};
            last_grant_q <= IDW'(PORTS - 1);
            m_valid_q    <= 1'b0;
            m_addr_q     <= {ADDR_WIDTH{1'b0}};
            m_wdata_q    <= {DATA_WIDTH{1'b0}};
            m_we_q       <= 1'b0;
            busy_q       <= 1'b0;
            rsp_valid_q  <= {PORTS{1'b0}};
            rsp_rdata_q  <= {DATA_WIDTH{1'b0}};
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            m_valid_q    <= m_valid_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            m_we_q       <= m_we_d;
            busy_q       <= busy_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

`ifdef MEM_REQ_SCHEDULER_TIMEOUT_EN
    // Watchdog counter for the outstanding response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // req_ready is the same-cycle accept strobe, held low while reset is asserted
    assign req_ready = rst ? {PORTS{1'b0}} : req_ready_s;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign m_valid   = m_valid_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign m_we      = m_we_q;
    assign busy      = busy_q;
    assign grant_id  = grant_id_q;

endmodule

// File: doc/mem_req_scheduler.md
MEM_REQ_SCHEDULER -- requirements
Module: mem_req_scheduler

Interface
REQ-001 SHALL have parameter PORTS, default 4: number of requesters, 2..16.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: request address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: write and read data width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255: response watchdog limit, used only under the Configuration macro.
REQ-005 SHALL have port clk  in  1: the single clock, rising edge.
REQ-006 SHALL have port rst  in  1: reset, asynchronous, active-high.
REQ-007 SHALL have port req_valid  in  PORTS: per-requester request valid.
REQ-008 SHALL have port req_ready  out  PORTS: per-requester request accepted.
REQ-009 SHALL have port req_addr  in  PORTS*ADDR_WIDTH: packed addresses, port i at slice i.
REQ-010 SHALL have port req_wdata  in  PORTS*DATA_WIDTH: packed write data.
REQ-011 SHALL have port req_we  in  PORTS: 1 = write, 0 = read.
REQ-012 SHALL have port rsp_valid  out  PORTS: one-hot response strobe to the owning requester.
REQ-013 SHALL have ports rsp_rdata  out  DATA_WIDTH and rsp_err  out  1: response payload, shared by all requesters.
REQ-014 SHALL have ports m_valid, m_addr, m_wdata, m_we (out) and m_ready (in): downstream request channel.
REQ-015 SHALL have ports m_rsp_valid, m_rsp_rdata, m_rsp_err (in): downstream response.
REQ-016 SHALL have ports busy  out  1 and grant_id  out  $clog2(PORTS): transaction in flight, and its owner.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE and WAIT_RESP.
REQ-018 In IDLE with any req_valid, SHALL pick a winner round-robin, LSB-first, starting at last_grant+1 and wrapping.
REQ-019 In the same IDLE cycle SHALL pulse req_ready[winner] for exactly 1 cycle, latch addr/wdata/we, register grant_id and go to ISSUE.
REQ-020 In ISSUE, m_valid SHALL be 1, starting the cycle after acceptance, with m_addr/m_wdata/m_we stable until m_ready.
REQ-021 On m_valid&&m_ready SHALL go to WAIT_RESP and deassert m_valid the next cycle.
REQ-022 In WAIT_RESP, on m_rsp_valid SHALL register rsp_valid[grant_id]=1 for 1 cycle (latency 1), copy rdata/err, set last_grant=grant_id and return to IDLE.
REQ-023 SHALL ignore m_rsp_valid in IDLE or ISSUE.
REQ-024 SHALL allow only one transaction in flight; req_ready SHALL be 0 outside IDLE.
REQ-025 busy SHALL be 1 in ISSUE and WAIT_RESP.
REQ-026 rsp_rdata and rsp_err SHALL hold their last values between strobes.
REQ-027 SHALL produce no grant in IDLE when no requester is valid; last_grant SHALL be unchanged.

Reset
REQ-028 Asserting rst SHALL asynchronously force: state IDLE; req_ready, rsp_valid, m_valid, busy = 0; grant_id = 0; rsp_rdata, rsp_err = 0; last_grant = PORTS-1, so port 0 wins first.
REQ-029 Reset during ISSUE or WAIT_RESP SHALL drop the transaction; no response SHALL be emitted for it.

Configuration
REQ-030 With MEM_REQ_SCHEDULER_TIMEOUT_EN defined, a counter SHALL run in WAIT_RESP.
REQ-031 When that counter reaches TIMEOUT_CYCLES, the block SHALL strobe rsp_valid[grant_id] with rsp_err=1 and rsp_rdata=0, then go to IDLE.
REQ-032 Any later m_rsp_valid for a timed-out transaction SHALL be ignored.
REQ-033 Without MEM_REQ_SCHEDULER_TIMEOUT_EN, the counter SHALL be absent and WAIT_RESP SHALL wait indefinitely.

Structure
REQ-034 Package mem_req_scheduler_pkg SHALL hold the FSM state enum and the state-encoding constants.
REQ-035 Sub-module rr_select (combinational: request vector plus last_grant in, winner index plus valid out) SHALL perform the round-robin pick.

Verification
REQ-036 Reset, then req_valid=4'b1111 held: grants SHALL follow 0,1,2,3,0, each with one req_ready pulse.
REQ-037 Port 2 read, m_ready at 3rd ISSUE cycle, m_rsp_valid with rdata=0xDEADBEEF: rsp_valid=4'b0100 and rsp_rdata=0xDEADBEEF exactly 1 cycle later.
REQ-038 Port 1 write with m_ready=0 for 5 cycles: m_addr/m_wdata/m_we SHALL stay stable across all 5 cycles; req_ready SHALL be 0 for all ports.
REQ-039 rst asserted mid-WAIT_RESP: outputs SHALL be 0 immediately, with no clock edge; a later m_rsp_valid SHALL yield no rsp_valid.
REQ-040 With MEM_REQ_SCHEDULER_TIMEOUT_EN and TIMEOUT_CYCLES=8, no response: rsp_err=1 and rsp_rdata=0 after 8 WAIT_RESP cycles; a late m_rsp_valid SHALL be ignored.
